cska26_norm_round: RTL and testbench

Two-stage pipelined normalize-and-round stage that consumes the 27-bit result `{cout, S[26:1]}` of the 26-bit carry-skip adder. It left-justifies the value with a leading-zero count, then rounds it to a 24-bit mantissa with a leading one at bit 24. Flow control is valid/ready with full backpressure, so the stage can sit between the adder and a registered consumer such as an exponent-update or writeback stage.

---
 rtl/cska26_norm_round.sv | 100 ++++++++++
 tb/tb_cska26_norm_round.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/cska26_norm_round.sv
// cska26_norm_round: two-stage normalize (leading-zero shift) and round of {cout, S} to a 24-bit mantissa.
// Define CSKA_NORM_RNE_EN for round-to-nearest-even; otherwise the mantissa is truncated.
module cska26_norm_round #(
  parameter int WIDTH  = 26,
  parameter int MANT_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH:1]    in_sum,
  input  logic              in_cout,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MANT_W:1]   out_mant,
  output logic [5:1]        out_shift,
  output logic              out_round_ovf,
  output logic              out_inexact,
  output logic              out_zero
);
  logic              s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
  logic [WIDTH:0]    v1_q, v1_d;
  logic [4:0]        lz1_q, lz1_d;
  logic              zero1_q, zero1_d;
  logic [MANT_W-1:0] mant_q, mant_d;
  logic [4:0]        shift_q, shift_d;
  logic              ovf_q, ovf_d, inex_q, inex_d, zero_q, zero_d;
  logic              s2_adv, s1_load;
  logic [WIDTH:0]    v_in, n;
  logic [4:0]        lz;
  logic [MANT_W-1:0] mant_n;
  logic              ovf_n;
`ifdef CSKA_NORM_RNE_EN
  logic [MANT_W:0]   sum;
`endif
  assign v_in          = {in_cout, in_sum};
  assign s2_adv        = s1_valid_q && (!s2_valid_q || out_ready);
  assign in_ready      = !s1_valid_q || s2_adv;
  assign s1_load       = in_ready && in_valid;
  assign out_valid     = s2_valid_q;
  assign out_mant      = mant_q;
  assign out_shift     = shift_q;
  assign out_round_ovf = ovf_q;
  assign out_inexact   = inex_q;
  assign out_zero      = zero_q;
  // ascending scan: the last set bit found is the most significant one
  always_comb begin
    lz = 5'd0;
    for (int i = 0; i <= WIDTH; i++)
      if (v_in[i]) lz = 5'(WIDTH - i);
  end
  always_comb begin
    n = v1_q << lz1_q;
`ifdef CSKA_NORM_RNE_EN
    sum    = {1'b0, n[WIDTH:3]} + (MANT_W+1)'(n[2] & (|n[1:0] | n[3]));
    ovf_n  = sum[MANT_W];
    mant_n = ovf_n ? {1'b1, {(MANT_W-1){1'b0}}} : sum[MANT_W-1:0];
`else
    ovf_n  = 1'b0;
    mant_n = n[WIDTH:3];
`endif
  end
  always_comb begin
    s1_valid_d = s1_load ? 1'b1 : (s2_adv ? 1'b0 : s1_valid_q);
    s2_valid_d = s2_adv ? 1'b1 : (out_ready ? 1'b0 : s2_valid_q);
    v1_d       = s1_load ? v_in : v1_q;
    lz1_d      = s1_load ? lz : lz1_q;
    zero1_d    = s1_load ? (v_in == '0) : zero1_q;
    mant_d     = s2_adv ? mant_n : mant_q;
    shift_d    = s2_adv ? lz1_q : shift_q;
    ovf_d      = s2_adv ? ovf_n : ovf_q;
    inex_d     = s2_adv ? |n[2:0] : inex_q;
    zero_d     = s2_adv ? zero1_q : zero_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      v1_q       <= '0;
      lz1_q      <= '0;
      zero1_q    <= 1'b0;
      mant_q     <= '0;
      shift_q    <= '0;
      ovf_q      <= 1'b0;
      inex_q     <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      v1_q       <= v1_d;
      lz1_q      <= lz1_d;
      zero1_q    <= zero1_d;
      mant_q     <= mant_d;
      shift_q    <= shift_d;
      ovf_q      <= ovf_d;
      inex_q     <= inex_d;
      zero_q     <= zero_d;
    end
  end
endmodule

// File: tb/tb_cska26_norm_round.sv
// tb_cska26_norm_round: random and directed stimulus checked against an arithmetic normalize/round model.
module tb_cska26_norm_round;
  typedef struct {
    logic [23:0] mant;
    logic [4:0]  sh;
    logic        ovf, inex, zero;
  } exp_t;
  logic        clk = 0, rst = 1;
  logic        in_valid = 0, in_ready, in_cout = 0;
  logic [26:1] in_sum = '0;
  logic        out_valid, out_ready = 1;
  logic [24:1] out_mant;
  logic [5:1]  out_shift;
  logic        out_round_ovf, out_inexact, out_zero;
  int          n_chk = 0, n_err = 0;
  exp_t        q[$];
  exp_t        held;
  logic        hold_prev = 0;
  cska26_norm_round dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_sum(in_sum), .in_cout(in_cout), .out_valid(out_valid), .out_ready(out_ready),
    .out_mant(out_mant), .out_shift(out_shift), .out_round_ovf(out_round_ovf),
    .out_inexact(out_inexact), .out_zero(out_zero)
  );
  always #5 clk = ~clk;
  function automatic exp_t model(logic [26:0] v);
    exp_t e;
    int p = 0;
    longint nv, mant, rem, inc;
    for (int i = 0; i < 27; i++) if (v[i]) p = i + 1;
    e.sh = (p == 0) ? 5'd0 : 5'(27 - p);
    nv = longint'(v) * (longint'(1) << e.sh);
    mant = nv / 8;
    rem = nv % 8;
    inc = 0;
`ifdef CSKA_NORM_RNE_EN
    if (rem > 4 || (rem == 4 && mant % 2 == 1)) inc = 1;
`endif
    mant = mant + inc;
    e.ovf = (mant == (longint'(1) << 24));
    if (e.ovf) mant = longint'(1) << 23;
    e.mant = 24'(mant);
    e.inex = (rem != 0);
    e.zero = (v == 0);
    return e;
  endfunction
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask
  task automatic mon();
    exp_t e;
    if (hold_prev) begin
      chk("hold_valid", 32'(out_valid), 1);
      chk("hold_mant", 32'(out_mant), 32'(held.mant));
      chk("hold_shift", 32'(out_shift), 32'(held.sh));
      chk("hold_flags", {29'd0, out_round_ovf, out_inexact, out_zero}, {29'd0, held.ovf, held.inex, held.zero});
    end
    hold_prev = out_valid && !out_ready;
    held = '{out_mant, out_shift, out_round_ovf, out_inexact, out_zero};
    if (in_valid && in_ready) q.push_back(model({in_cout, in_sum}));
    if (out_valid && out_ready) begin
      if (q.size() == 0) chk("spurious_out", 32'(out_valid), 0);
      else begin
        e = q.pop_front();
        chk("mant", 32'(out_mant), 32'(e.mant));
        chk("shift", 32'(out_shift), 32'(e.sh));
        chk("ovf", 32'(out_round_ovf), 32'(e.ovf));
        chk("inexact", 32'(out_inexact), 32'(e.inex));
        chk("zero", 32'(out_zero), 32'(e.zero));
      end
    end
  endtask
  task automatic cyc();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
  endtask
  task automatic setv(logic [26:0] v);
    {in_cout, in_sum} = v;
  endtask
  task automatic dir(logic [26:0] v);
    setv(v);
    in_valid = 1;
    out_ready = 1;
    @(negedge clk);
    chk("dir_in_ready", 32'(in_ready), 1);
    mon();
    @(posedge clk);
    #1;
    in_valid = 0;
    @(negedge clk);
    chk("latency_k1", 32'(out_valid), 0);
    mon();
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("latency_k2", 32'(out_valid), 1);
    mon();
    @(posedge clk);
    #1;
  endtask
  task automatic drain();
    in_valid = 0;
    out_ready = 1;
    for (int i = 0; i < 12 && q.size() != 0; i++) cyc();
    chk("drained", 32'(q.size()), 0);
  endtask
  initial begin
    int acc;
    logic [26:0] rv;
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_mant", 32'(out_mant), 0);
    @(posedge clk);
    #2 rst = 0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_flags", {27'd0, out_shift, out_round_ovf, out_inexact, out_zero}, 0);
    dir(27'h4000000);
    dir(27'h0000001);
    dir(27'h7FFFFFF);
    dir(27'h4000004);
    dir(27'h400000C);
    dir(27'h0000000);
    dir(27'h0FFFFFF);
    dir(27'h000000F);
    // constant expectations independent of the model for the build-invariant cases
    chk("k_carry_only", 32'(model(27'h4000000).mant), 32'h800000);
    chk("k_smallest_shift", 32'(model(27'h0000001).sh), 26);
`ifdef CSKA_NORM_RNE_EN
    chk("k_ovf", 32'({model(27'h7FFFFFF).mant, model(27'h7FFFFFF).ovf}), {8'd0, 24'h800000, 1'b1} >> 1 << 1 | 1);
`else
    chk("k_trunc", 32'(model(27'h7FFFFFF).mant), 32'hFFFFFF);
`endif
    out_ready = 0;
    in_valid = 1;
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      setv(27'($urandom));
      @(negedge clk);
      if (in_ready) acc++;
      mon();
      @(posedge clk);
      #1;
    end
    chk("bp_accepted", 32'(acc), 2);
    chk("bp_in_ready", 32'(in_ready), 0);
    out_ready = 1;
    for (int i = 0; i < 20 && acc < 4; i++) begin
      setv(27'($urandom));
      @(negedge clk);
      if (in_ready) acc++;
      mon();
      @(posedge clk);
      #1;
    end
    chk("bp_total", 32'(acc), 4);
    drain();
    for (int i = 0; i < 400; i++) begin
      rv = 27'($urandom >> $urandom_range(0, 31));
      if ($urandom_range(0, 9) == 0) rv = 27'h7FFFFFF;
      setv(rv);
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end
    drain();
    out_ready = 0;
    in_valid = 1;
    setv(27'h1234567);
    cyc();
    setv(27'h0000ABC);
    cyc();
    in_valid = 0;
    #2 rst = 1;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_in_ready", 32'(in_ready), 1);
    q.delete();
    hold_prev = 0;
    @(posedge clk);
    #2 rst = 0;
    out_ready = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_rst_idle", 32'(out_valid), 0);
      mon();
      @(posedge clk);
      #1;
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
